// File: rtl/semaforo_ctrl_pkg.sv
// Shared types and constants for the semaforo_ctrl traffic-light controller.
// The PEDESTRIAN_EN macro only affects rtl/semaforo_ctrl.sv; this package is build-independent.
package semaforo_ctrl_pkg;

    localparam int CNT_W = 8;

    // Lamp encodings, bit order {red, yellow, green}
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    // Fixed successor in the road cycle; the ALLRED_B branch to PED_WALK is decided by the top.
    function automatic state_t road_next(input state_t s);
        case (s)
            NS_GREEN:  road_next = NS_YELLOW;
            NS_YELLOW: road_next = ALLRED_A;
            ALLRED_A:  road_next = EW_GREEN;
            EW_GREEN:  road_next = EW_YELLOW;
            EW_YELLOW: road_next = ALLRED_B;
            default:   road_next = NS_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_ctrl_tick_sync.sv
// Two-flop synchronizer for the slow tick_in time base plus a registered rising-edge detector.
// A rising edge sampled by clk produces a one-cycle pulse three cycles later.
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Pulse is registered so downstream logic sees a clean, glitch-free strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/semaforo_ctrl.sv
// Two-road traffic-light controller stepped by a synchronized slow tick.
// Define PEDESTRIAN_EN to add the pedestrian walk phase after ALLRED_B.
module semaforo_ctrl
    import semaforo_ctrl_pkg::*;
#(
    parameter int GREEN_T  = 5,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             ped_req,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             walk,
    output logic [7:0]       remaining,
    output logic             tick_pulse
);

    state_t            state;
    state_t            state_nxt;
    state_t            succ;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              tick;
    logic              ped_pending;

    tick_sync u_tick_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (tick_in),
        .pulse    (tick)
    );

    assign tick_pulse = tick;
    assign remaining  = cnt;

    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   load_val = CNT_W'(GREEN_T - 1);
            NS_YELLOW, EW_YELLOW: load_val = CNT_W'(YELLOW_T - 1);
            ALLRED_A, ALLRED_B:   load_val = CNT_W'(ALLRED_T - 1);
            default:              load_val = CNT_W'(WALK_T - 1);
        endcase
    endfunction

`ifdef PEDESTRIAN_EN
    // Clearing on PED_WALK entry wins over a simultaneous request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ped_pending <= 1'b0;
        end else if (tick && cnt == '0 && state == ALLRED_B && ped_pending) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end
    end
`else
    assign ped_pending = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= NS_GREEN;
            cnt   <= CNT_W'(GREEN_T - 1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        succ      = road_next(state);
        if (state == ALLRED_B && ped_pending) begin
            succ = PED_WALK;
        end
        if (tick) begin
            if (cnt == '0) begin
                state_nxt = succ;
                cnt_nxt   = load_val(succ);
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    // Moore lamp decode from the registered state
    always_comb begin
        ns_light = RED;
        ew_light = RED;
        case (state)
            NS_GREEN:  ns_light = GREEN;
            NS_YELLOW: ns_light = YELLOW;
            EW_GREEN:  ew_light = GREEN;
            EW_YELLOW: ew_light = YELLOW;
            default: begin
                ns_light = RED;
                ew_light = RED;
            end
        endcase
    end

`ifdef PEDESTRIAN_EN
    assign walk = (state == PED_WALK);
`else
    // ped_req is deliberately ignored in this build; the AND keeps the port referenced
    assign walk = ped_req & 1'b0;
`endif

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench for semaforo_ctrl with GREEN_T=3, YELLOW_T=1, ALLRED_T=1, WALK_T=2.
// Expected lamp sequence differs when PEDESTRIAN_EN is defined.
module tb_semaforo_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam int NV = 22;

    typedef struct {
        logic       ped;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [7:0] rem;
        logic       walk;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [7:0] remaining;
    logic       tick_pulse;

    int total;
    int bad;
    vec_t vecs[NV];

    semaforo_ctrl #(
        .GREEN_T  (3),
        .YELLOW_T (1),
        .ALLRED_T (1),
        .WALK_T   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .ped_req    (ped_req),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .walk       (walk),
        .remaining  (remaining),
        .tick_pulse (tick_pulse)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // never-green: both roads must not show green/yellow together
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("never_green", 32'((ns_light[1:0] != 2'b00) && (ew_light[1:0] != 2'b00)), 32'd0);
        end
    end

    task automatic do_tick();
        @(negedge clk);
        tick_in = 1'b1;
        repeat (4) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_ped();
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic p, input logic [2:0] n, input logic [2:0] e,
                                input logic [7:0] r, input logic w);
        vec_t v;
        v.ped = p; v.ns = n; v.ew = e; v.rem = r; v.walk = w;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic [2:0] n, input logic [2:0] e,
                                 input logic [7:0] r, input logic w);
        check({tag, ".ns"}, 32'(ns_light), 32'(n));
        check({tag, ".ew"}, 32'(ew_light), 32'(e));
        check({tag, ".rem"}, 32'(remaining), 32'(r));
        check({tag, ".walk"}, 32'(walk), 32'(w));
    endtask

    initial begin
        int pulses;
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        tick_in = 1'b0;
        ped_req = 1'b0;

        // expected state after each tick; ped_req pulsed before vector 5 (EW_GREEN)
        vecs[0] = mk(0, G, R, 1, 0);
        vecs[1] = mk(0, G, R, 0, 0);
        vecs[2] = mk(0, Y, R, 0, 0);
        vecs[3] = mk(0, R, R, 0, 0);
        vecs[4] = mk(0, R, G, 2, 0);
        vecs[5] = mk(1, R, G, 1, 0);
        vecs[6] = mk(0, R, G, 0, 0);
        vecs[7] = mk(0, R, Y, 0, 0);
        vecs[8] = mk(0, R, R, 0, 0);
`ifdef PEDESTRIAN_EN
        vecs[9]  = mk(0, R, R, 1, 1);
        vecs[10] = mk(0, R, R, 0, 1);
        vecs[11] = mk(0, G, R, 2, 0);
        vecs[12] = mk(0, G, R, 1, 0);
        vecs[13] = mk(0, G, R, 0, 0);
        vecs[14] = mk(0, Y, R, 0, 0);
        vecs[15] = mk(0, R, R, 0, 0);
        vecs[16] = mk(0, R, G, 2, 0);
        vecs[17] = mk(0, R, G, 1, 0);
        vecs[18] = mk(0, R, G, 0, 0);
        vecs[19] = mk(0, R, Y, 0, 0);
        vecs[20] = mk(0, R, R, 0, 0);
        vecs[21] = mk(0, G, R, 2, 0);
`else
        vecs[9]  = mk(0, G, R, 2, 0);
        vecs[10] = mk(0, G, R, 1, 0);
        vecs[11] = mk(0, G, R, 0, 0);
        vecs[12] = mk(0, Y, R, 0, 0);
        vecs[13] = mk(0, R, R, 0, 0);
        vecs[14] = mk(0, R, G, 2, 0);
        vecs[15] = mk(0, R, G, 1, 0);
        vecs[16] = mk(0, R, G, 0, 0);
        vecs[17] = mk(0, R, Y, 0, 0);
        vecs[18] = mk(0, R, R, 0, 0);
        vecs[19] = mk(0, G, R, 2, 0);
        vecs[20] = mk(0, G, R, 1, 0);
        vecs[21] = mk(0, G, R, 0, 0);
`endif

        // reset values while held and after release
        repeat (3) @(negedge clk);
        check_outputs("rst_held", G, R, 8'd2, 1'b0);
        check("rst_held.pulse", 32'(tick_pulse), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("rst_rel", G, R, 8'd2, 1'b0);
        check("rst_rel.pulse", 32'(tick_pulse), 32'd0);

        // edge detect: pulse only on the third edge after a rise, none on the fall
        tick_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("edge_rise_c%0d", k), 32'(tick_pulse), 32'(k == 3));
        end
        tick_in = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("edge_fall_c%0d", k), 32'(tick_pulse), 32'd0);
        end
        check("edge_rem", 32'(remaining), 32'd1);

        // table-driven full cycle
        do_reset();
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].ped) pulse_ped();
            do_tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].ns, vecs[i].ew, vecs[i].rem, vecs[i].walk);
        end

        // asynchronous reset in the middle of EW_YELLOW
        do_reset();
        repeat (8) do_tick();
        check_outputs("pre_mid_rst", R, Y, 8'd0, 1'b0);
        #2 rst = 1'b0;
        #1 check_outputs("mid_rst", G, R, 8'd2, 1'b0);
        check("mid_rst.pulse", 32'(tick_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_tick();
        check_outputs("mid_rst_tick", G, R, 8'd1, 1'b0);

        // tick_in rises one cycle before reset release: exactly one pulse
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tick_pulse === 1'b1) pulses++;
        end
        check("glitch_pulses", 32'(pulses), 32'd1);
        check("glitch_rem", 32'(remaining), 32'd1);
        tick_in = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_fall_rem", 32'(remaining), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/semaforo_ctrl.md
SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- GREEN_T, 5: green duration per road, in ticks; legal range 1..255.
- YELLOW_T, 2: yellow duration per road, in ticks; legal range 1..255.
- ALLRED_T, 1: all-red clearance duration, in ticks; legal range 1..255.
- WALK_T, 4: pedestrian walk duration, in ticks; legal range 1..255.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- tick_in, in, 1: slow toggling time base from the clock divider; asynchronous to clk.
- ped_req, in, 1: pedestrian request, level, synchronous to clk.
- ns_light, out, 3: north-south lamps {red, yellow, green}.
- ew_light, out, 3: east-west lamps {red, yellow, green}.
- walk, out, 1: pedestrian walk lamp.
- remaining, out, 8: ticks left in the current phase, minus one.
- tick_pulse, out, 1: single-cycle pulse on each tick_in rising edge.

Function
REQ-003 The block SHALL synchronize tick_in through two flops, then rising-edge detect it against one further flop (prev).
REQ-004 tick_pulse SHALL be high for exactly one clk cycle, 3 cycles after a tick_in rising edge sampled by clk; tick_in falling edges SHALL produce no pulse.
REQ-005 The FSM SHALL have states NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B and PED_WALK, cycled in that order; PED_WALK exists only under REQ-015.
REQ-006 On entry to each state the phase counter SHALL be loaded with (duration - 1); the durations are GREEN_T for both greens, YELLOW_T for both yellows, ALLRED_T for both all-reds, WALK_T for PED_WALK.
REQ-007 On tick_pulse with counter > 0 the counter SHALL decrement by 1.
REQ-008 On tick_pulse with counter == 0 the FSM SHALL advance to the next state and load that state's duration - 1; a duration of 1 therefore lasts exactly one tick.
REQ-009 State and counter SHALL change only on tick_pulse cycles; all lamp outputs SHALL be Moore outputs, decoded from the registered state and valid the cycle after the advancing edge.
REQ-010 Lamp decode:
- NS_GREEN: ns_light=001, ew_light=100.
- NS_YELLOW: ns_light=010, ew_light=100.
- EW_GREEN: ns_light=100, ew_light=001.
- EW_YELLOW: ns_light=100, ew_light=010.
- ALLRED_A, ALLRED_B, PED_WALK: both roads 100.
REQ-011 Outputs never-green: ns_light and ew_light SHALL never both contain green or yellow in the same cycle.
REQ-012 remaining SHALL equal the phase counter at all times.

Reset
REQ-013 While rst=0 the block SHALL hold the following values:
- state = NS_GREEN, counter = GREEN_T-1.
- synchronizer flops and prev = 0; ped_pending = 0.
- Resulting outputs: tick_pulse=0, walk=0, ns_light=001, ew_light=100.
REQ-014 A tick_in held high across reset release SHALL yield exactly one tick_pulse; reset asserted mid-phase SHALL abort the phase immediately, with no partial transition.

Configuration
REQ-015 Macro PEDESTRIAN_EN, when defined:
- ped_req=1 SHALL set ped_pending, which holds until PED_WALK is entered.
- From ALLRED_B, the advancing tick SHALL go to PED_WALK if ped_pending=1, otherwise to NS_GREEN.
- ped_pending SHALL clear on the entry cycle of PED_WALK; a ped_req during PED_WALK SHALL set it again for the next cycle round.
- walk SHALL be 1 only in PED_WALK.
REQ-016 Without PEDESTRIAN_EN:
- ped_req SHALL be ignored and walk SHALL be tied to 0.
- ALLRED_B SHALL always advance to NS_GREEN, and PED_WALK SHALL be unreachable.
- The port list SHALL be identical to the PEDESTRIAN_EN build.

Structure
REQ-017 A shared package SHALL hold:
- the state enumeration;
- the lamp encodings RED=100, YELLOW=010, GREEN=001;
- the counter width of 8.
REQ-018 Synchronizer plus edge detector SHALL be a sub-module named tick_sync (ports: clk, rst, async_in, pulse).

Verification (GREEN_T=3, YELLOW_T=1, ALLRED_T=1, WALK_T=2)
REQ-019 Reset: apply rst=0, then release -> ns_light=001, ew_light=100, remaining=2, walk=0, tick_pulse=0.
REQ-020 Edge detect: tick_in rises at cycle N -> tick_pulse=1 only at cycle N+3; tick_in fall -> no pulse.
REQ-021 Full cycle, no pedestrian: 10 ticks -> sequence NS_GREEN(3), NS_YELLOW(1), ALLRED_A(1), EW_GREEN(3), EW_YELLOW(1), ALLRED_B(1), back to NS_GREEN with remaining=2; never-green assertion holds throughout.
REQ-022 PEDESTRIAN_EN: pulse ped_req=1 for 1 cycle during EW_GREEN -> after ALLRED_B, 2 ticks of PED_WALK with walk=1 and both roads 100, then NS_GREEN; the next round is without walk.
REQ-023 Reset mid-phase: apply rst=0 during EW_YELLOW -> outputs return to the REQ-013 values asynchronously; the next tick_pulse decrements remaining 2->1.
REQ-024 Glitch-free time base: tick_in toggled 1 cycle before rst release -> at most one tick_pulse, and the counter decrements by at most 1.
